// File: rtl/wb_trace_fifo.sv
// Write-back trace capture FIFO: filters register-file writes from the core's
// debug port into a first-word-fall-through queue, counting records lost to overflow.
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              debug_wb_pc,
  input  logic [3:0]               debug_wb_rf_wen,
  input  logic [4:0]               debug_wb_rf_wnum,
  input  logic [31:0]              debug_wb_rf_wdata,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_pc,
  output logic [3:0]               trace_wen,
  output logic [4:0]               trace_wnum,
  output logic [31:0]              trace_wdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           wr_entry;
  entry_t           head;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic cap, full, empty, pop, push, drop;

  always_comb begin
    wr_entry = '{pc:    debug_wb_pc,
                 wen:   debug_wb_rf_wen,
                 wnum:  debug_wb_rf_wnum,
                 wdata: debug_wb_rf_wdata};

    cap   = (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    full  = (level_q == (AW+1)'(DEPTH));
    empty = (level_q == '0);
    pop   = !empty && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push  = cap && (!full || pop);
    drop  = cap && full && !pop;
  end

  // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    // Clear first, then account for a coincident drop so it is never lost.
    if (clear_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (clear_ovf)         drop_cnt_d = CNT_W'(1);
      else if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the occupancy counter guards stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head        = mem_q[rd_ptr_q];
  assign trace_valid = !empty;
  assign trace_pc    = empty ? 32'd0 : head.pc;
  assign trace_wen   = empty ? 4'd0  : head.wen;
  assign trace_wnum  = empty ? 5'd0  : head.wnum;
  assign trace_wdata = empty ? 32'd0 : head.wdata;
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed and random steps scored against
// a queue-based reference model; a second instance with a 2-bit counter covers saturation.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] pc, wdata;
  logic [3:0]  wen;
  logic [4:0]  wnum;
  logic        ready, clr;

  logic        t_valid;
  logic [31:0] t_pc, t_wdata;
  logic [3:0]  t_wen;
  logic [4:0]  t_wnum;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  // Second instance: FIFO never drained, narrow saturating drop counter.
  logic [3:0]  wen2;
  logic [4:0]  wnum2;
  logic        clr2;
  logic        t_valid2;
  logic [31:0] t_pc2, t_wdata2;
  logic [3:0]  t_wen2;
  logic [4:0]  t_wnum2;
  logic [4:0]  level2;
  logic        overflow2;
  logic [1:0]  drop_cnt2;

  int checks = 0;
  int errors = 0;

  logic [72:0] mq [$];
  int          m_drops;
  bit          m_ovf;
  int          m2_level;
  int          m2_drops;
  bit          m2_ovf;

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .debug_wb_pc(pc), .debug_wb_rf_wen(wen), .debug_wb_rf_wnum(wnum), .debug_wb_rf_wdata(wdata),
    .trace_valid(t_valid), .trace_ready(ready),
    .trace_pc(t_pc), .trace_wen(t_wen), .trace_wnum(t_wnum), .trace_wdata(t_wdata),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .clear_ovf(clr)
  );

  wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .debug_wb_pc(32'h0000_1000), .debug_wb_rf_wen(wen2), .debug_wb_rf_wnum(wnum2),
    .debug_wb_rf_wdata(32'hcafe_0000),
    .trace_valid(t_valid2), .trace_ready(1'b0),
    .trace_pc(t_pc2), .trace_wen(t_wen2), .trace_wnum(t_wnum2), .trace_wdata(t_wdata2),
    .level(level2), .overflow(overflow2), .drop_cnt(drop_cnt2), .clear_ovf(clr2)
  );

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    logic [72:0] exp_head;
    exp_head = (mq.size() > 0) ? mq[0] : 73'd0;
    check({tag, ".valid"}, 73'(t_valid), 73'(mq.size() > 0));
    check({tag, ".level"}, 73'(level), 73'(mq.size()));
    check({tag, ".head"}, {t_pc, t_wen, t_wnum, t_wdata}, exp_head);
    check({tag, ".ovf"}, 73'(overflow), 73'(m_ovf));
    check({tag, ".drops"}, 73'(drop_cnt), 73'(m_drops));
    check({tag, ".lvl2"}, 73'(level2), 73'(m2_level));
    check({tag, ".ovf2"}, 73'(overflow2), 73'(m2_ovf));
    check({tag, ".drops2"}, 73'(drop_cnt2), 73'(m2_drops));
  endtask

  // Reference model advances from the inputs present before the edge, then outputs are compared.
  task automatic tick(input string tag);
    bit cap, pop, drop, cap2, drop2;
    logic [72:0] gone;
    cap  = (wen != 0) && (wnum != 0);
    pop  = (mq.size() > 0) && ready;
    drop = cap && (mq.size() == DEPTH) && !pop;
    if (pop) gone = mq.pop_front();
    if (cap && !drop) mq.push_back({pc, wen, wnum, wdata});
    if (clr) begin m_drops = 0; m_ovf = 0; end
    if (drop) begin m_drops = (m_drops < 65535) ? m_drops + 1 : 65535; m_ovf = 1; end

    cap2  = (wen2 != 0) && (wnum2 != 0);
    drop2 = cap2 && (m2_level == DEPTH);
    if (cap2 && !drop2) m2_level++;
    if (clr2) begin m2_drops = 0; m2_ovf = 0; end
    if (drop2) begin m2_drops = (m2_drops < 3) ? m2_drops + 1 : 3; m2_ovf = 1; end

    @(posedge clk);
    @(negedge clk);
    compare(tag);
  endtask

  task automatic drive(input logic [3:0] w, input logic [4:0] n, input logic [31:0] p, input logic [31:0] d);
    wen = w; wnum = n; pc = p; wdata = d;
  endtask

  task automatic model_reset();
    mq.delete();
    m_drops = 0; m_ovf = 0;
    m2_level = 0; m2_drops = 0; m2_ovf = 0;
  endtask

  initial begin
    reset = 1'b1;
    drive(4'h0, 5'd0, 32'h0, 32'h0);
    ready = 1'b0; clr = 1'b0;
    wen2 = 4'h0; wnum2 = 5'd0; clr2 = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare("reset");
    reset = 1'b0;

    // Filter: zero register and zero enables are ignored.
    drive(4'hf, 5'd0, 32'h1, 32'h1);                 tick("filt_r0");
    drive(4'h0, 5'd5, 32'h2, 32'h2);                 tick("filt_wen0");
    drive(4'h3, 5'd7, 32'hbfc0_0010, 32'h0000_1234); tick("filt_cap");
    check("filt_level", 73'(level), 73'd1);
    check("filt_head", {t_pc, t_wen, t_wnum, t_wdata}, {32'hbfc0_0010, 4'h3, 5'd7, 32'h0000_1234});
    drive(4'h0, 5'd0, 32'h0, 32'h0);
    ready = 1'b1;                                     tick("filt_drain");

    // Order and wrap with the consumer always ready.
    for (int i = 0; i < 40; i++) begin
      drive(4'hf, 5'd1, 32'h8000_0000 + 32'(i * 4), 32'(i));
      tick("order");
      check("order_wdata", 73'(t_wdata), 73'(i));
      check("order_level_le1", 73'(level <= 5'd1), 73'd1);
    end
    drive(4'h0, 5'd0, 32'h0, 32'h0);                 tick("order_tail");
    check("order_drops", 73'(drop_cnt), 73'd0);

    // Full and drop: DEPTH+3 captures with no consumer.
    ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive(4'h1, 5'd2, 32'h100 + 32'(i), 32'd100 + 32'(i));
      tick("fill");
    end
    check("full_level", 73'(level), 73'd16);
    check("full_ovf", 73'(overflow), 73'd1);
    check("full_drops", 73'(drop_cnt), 73'd3);
    check("full_head", 73'(t_wdata), 73'd100);

    // Push and pop together at full.
    ready = 1'b1;
    drive(4'hc, 5'd9, 32'h999, 32'd999);             tick("pushpop_full");
    check("pushpop_level", 73'(level), 73'd16);
    check("pushpop_drops", 73'(drop_cnt), 73'd3);
    check("pushpop_head", 73'(t_wdata), 73'd101);

    drive(4'h0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < DEPTH - 1) check("drain_order", 73'(t_wdata), 73'(101 + i));
      else               check("drain_last", 73'(t_wdata), 73'd999);
      tick("drain");
    end
    check("drain_empty", 73'(t_valid), 73'd0);
    clr = 1'b1;                                       tick("clear_main");
    clr = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) wnum = 5'd0;
      ready = ($urandom_range(0, 2) != 0);
      if (i > 200 && i < 260) ready = 1'b0;
      clr = ($urandom_range(0, 31) == 0);
      tick("rand");
    end
    clr = 1'b0;

    // Saturation on the 2-bit counter instance.
    drive(4'h0, 5'd0, 32'h0, 32'h0);
    ready = 1'b1;
    wen2 = 4'hf; wnum2 = 5'd3;
    for (int i = 0; i < DEPTH + 5; i++) tick("sat_fill");
    check("sat_drops", 73'(drop_cnt2), 73'd3);
    check("sat_ovf", 73'(overflow2), 73'd1);
    clr2 = 1'b1;                                      tick("sat_clr_drop");
    check("clr_drop_cnt", 73'(drop_cnt2), 73'd1);
    check("clr_drop_ovf", 73'(overflow2), 73'd1);
    wen2 = 4'h0;                                      tick("sat_clr_alone");
    check("clr_alone_cnt", 73'(drop_cnt2), 73'd0);
    check("clr_alone_ovf", 73'(overflow2), 73'd0);
    clr2 = 1'b0;

    // Asynchronous reset mid-burst at level 9.
    ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(4'h2, 5'd4, 32'h4000 + 32'(i), 32'h77 + 32'(i));
      tick("burst");
    end
    check("burst_level", 73'(level), 73'd9);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("arst_valid", 73'(t_valid), 73'd0);
    check("arst_level", 73'(level), 73'd0);
    check("arst_head", {t_pc, t_wen, t_wnum, t_wdata}, 73'd0);
    reset = 1'b0;
    drive(4'h5, 5'd6, 32'hbfc0_0100, 32'h0bad_f00d);
    check("post_rst_no_bypass", 73'(t_valid), 73'd0);
    tick("post_rst_cap");
    check("post_rst_head", {t_pc, t_wen, t_wnum, t_wdata}, {32'hbfc0_0100, 4'h5, 5'd6, 32'h0bad_f00d});
    drive(4'h0, 5'd0, 32'h0, 32'h0);
    ready = 1'b1;                                     tick("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Write-back trace capture buffer that sits directly downstream of the CPU core's trace debug interface (`debug_wb_pc` / `rf_wen` / `rf_wnum` / `rf_wdata`). Each cycle it filters out non-writing retirements and queues register-file writes in a first-word-fall-through FIFO. A testbench or debug host drains the queue through a valid/ready port without stalling the core. Overflow is never back-pressured: lost records are counted and flagged.

## Interface

Parameters:
- `DEPTH`, 16: number of FIFO entries; power of two, at least 2.
- `CNT_W`, 16: width of the drop counter.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `debug_wb_pc`  in  32: PC of the instruction retiring this cycle.
- `debug_wb_rf_wen`  in  4: byte write enables of the retiring register write.
- `debug_wb_rf_wnum`  in  5: destination register number.
- `debug_wb_rf_wdata`  in  32: write data.
- `trace_valid`  out  1: head entry present.
- `trace_ready`  in  1: consumer accepts head entry.
- `trace_pc`  out  32: head PC.
- `trace_wen`  out  4: head byte enables.
- `trace_wnum`  out  5: head register number.
- `trace_wdata`  out  32: head write data.
- `level`  out  log2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky flag, set when any record has been dropped.
- `drop_cnt`  out  CNT_W: saturating count of dropped records.
- `clear_ovf`  in  1: synchronous pulse that clears `overflow` and `drop_cnt`.

## Operation

- Capture: `cap = (debug_wb_rf_wen != 0) && (debug_wb_rf_wnum != 0)`. Writes to `$0` and cycles with zero enables are ignored.
- Entry format: {pc, wen, wnum, wdata}, 73 bits. It is stored unmodified; no byte merging.
- Pop: `pop = trace_valid && trace_ready`.
- Push: `push = cap && (!full || pop)`. When full, a simultaneous pop frees a slot, so the record is accepted and `level` is unchanged.
- Drop: `drop = cap && full && !pop`. The record is discarded.
- Storage:
  - Circular buffer with read and write pointers of log2(DEPTH) bits; both wrap naturally from DEPTH-1 to 0.
  - An occupancy counter distinguishes full from empty: `full = (level == DEPTH)`, `empty = (level == 0)`.
- `level` update: +1 on push without pop, -1 on pop without push, otherwise unchanged.
- Output:
  - `trace_valid = !empty`.
  - `trace_*` present the head entry combinationally from the read pointer.
  - `trace_*` are forced to 0 when `trace_valid` = 0.
- `drop_cnt`:
  - Increments on `drop`.
  - Saturates at all-ones and never wraps to 0.
- `overflow`: set on `drop`.
- `clear_ovf`:
  - Alone, it zeroes `drop_cnt` and `overflow`.
  - Coincident with `drop`, it results in `drop_cnt` = 1 and `overflow` = 1, so the new drop is not lost.
- `clear_ovf` does not affect FIFO contents.
- `trace_ready` while empty has no effect.

## Timing

- Reset values: read/write pointers 0, `level` 0, `trace_valid` 0, all `trace_*` 0, `overflow` 0, `drop_cnt` 0. Storage contents are don't-care.
- Reset asserted mid-operation empties the FIFO immediately (asynchronously); queued entries are lost.
- Latency: a record captured in cycle N appears at the head in cycle N+1 if the FIFO was empty. No same-cycle bypass is permitted.
- The consumer may hold `trace_ready` high continuously. One entry is popped per cycle, and `trace_*` update in the cycle after each pop.
- `trace_valid` never deasserts without a pop, except on reset.
- `level`, `overflow` and `drop_cnt` are registered. They reflect events of cycle N from cycle N+1.
- The FIFO sustains one push and one pop per cycle indefinitely, including at full.

## Test plan

- **Filter:** drive wen=4'hf/wnum=0, then wen=0/wnum=5, then wen=4'h3/wnum=7/pc=32'hbfc00010/wdata=32'h1234 with ready=0 -> `level`=1; head shows pc=32'hbfc00010, wen=4'h3, wnum=7, wdata=32'h1234.
- **Order and wrap:** push 40 sequential records (wdata=i, wnum=1) with ready=1 throughout -> consumer sees wdata 0..39 in order with none missing; `level` never exceeds 1; `drop_cnt`=0.
- **Full and drop:** ready=0, push DEPTH+3 records -> `level`=16, `overflow`=1, `drop_cnt`=3; draining yields the first 16 records in order.
- **Push and pop at full:** at full with ready=1 and a capture in the same cycle -> record accepted, `level` stays 16, `drop_cnt` unchanged.
- **Clear/saturation:** with CNT_W=2, 5 drops -> `drop_cnt`=3. `clear_ovf` coincident with a drop -> `drop_cnt`=1, `overflow`=1. `clear_ovf` alone -> both 0.
- **Async reset:** assert reset mid-burst with level=9 -> `trace_valid`, `level` and `trace_*` go to 0 before the next clock edge; after release, the first capture appears one cycle later.
